// File: rtl/param_cache_if.sv
// Request/response and backing-memory signals of param_cache.
// master: the requester plus backing-memory side; slave: the cache itself.
`timescale 1ns/1ps
interface param_cache_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              rd_req;
  logic              wr_req;
  logic              invalidate;
  logic              flush;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              hit;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_ack;

  modport master (
    output address, wdata, rd_req, wr_req, invalidate, flush,
    output mem_rdata, mem_rvalid, mem_ack,
    input  ready, rdata, hit, mem_rd_req, mem_wr_req, mem_addr, mem_wdata
  );

  modport slave (
    input  address, wdata, rd_req, wr_req, invalidate, flush,
    input  mem_rdata, mem_rvalid, mem_ack,
    output ready, rdata, hit, mem_rd_req, mem_wr_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/param_cache.sv
// param_cache: 2-way set-associative, write-through, no-write-allocate cache
// with single-beat-per-word line fills and zero-wait read hits.
// Optional macro CACHE_STATS_EN adds read_count / miss_count outputs.
`timescale 1ns/1ps
module param_cache #(
  parameter int ADDR_W    = 17,
  parameter int SET_BITS  = 6,
  parameter int WORD_BITS = 1,
  parameter int DATA_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  param_cache_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]   read_count,
  output logic [31:0]   miss_count
`endif
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << WORD_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS - WORD_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;

  state_t                 state_r, state_s;
  logic [DATA_W-1:0]      data_r  [0:1][0:SETS-1][0:WORDS-1];
  logic [TAG_W-1:0]       tag_r   [0:1][0:SETS-1];
  logic [1:0]             valid_r [0:SETS-1];
  logic                   lru_r   [0:SETS-1];
  logic [ADDR_W-1:0]      addr_r;
  logic [DATA_W-1:0]      wdata_r;
  logic [WORD_BITS-1:0]   beat_r;
  logic                   victim_r;

  logic [ADDR_W-1:0]      lk_addr_s;
  logic [TAG_W-1:0]       lk_tag_s;
  logic [SET_BITS-1:0]    lk_set_s;
  logic [WORD_BITS-1:0]   lk_off_s;
  logic                   hit0_s, hit1_s, lk_hit_s, hit_way_s, victim_s;
  logic                   beat_last_s, fill_beat_s, wr_ack_s;
  logic                   do_flush_s, do_inv_s, do_wr_s, rd_hit_s, fill_start_s;
  logic                   ready_s, hit_s, mem_rd_req_s, mem_wr_req_s;
  logic [DATA_W-1:0]      rdata_s, mem_wdata_s;
  logic [ADDR_W-1:0]      mem_addr_s;

  // In IDLE the live request is looked up; otherwise the latched one.
  assign lk_addr_s   = (state_r == IDLE) ? bus.address : addr_r;
  assign lk_tag_s    = lk_addr_s[ADDR_W-1 -: TAG_W];
  assign lk_set_s    = lk_addr_s[WORD_BITS +: SET_BITS];
  assign lk_off_s    = lk_addr_s[WORD_BITS-1:0];
  assign hit0_s      = valid_r[lk_set_s][0] && (tag_r[0][lk_set_s] == lk_tag_s);
  assign hit1_s      = valid_r[lk_set_s][1] && (tag_r[1][lk_set_s] == lk_tag_s);
  assign lk_hit_s    = hit0_s || hit1_s;
  assign hit_way_s   = hit0_s ? 1'b0 : 1'b1;
  assign beat_last_s = (beat_r == WORD_BITS'(WORDS - 1));
  assign fill_beat_s = (state_r == FILL) && bus.mem_rvalid;
  assign wr_ack_s    = (state_r == WRITE) && bus.mem_ack;

  // Victim choice: an invalid way beats a valid one, else the LRU bit decides.
  always_comb begin
    victim_s = 1'b0;
    if (valid_r[lk_set_s] == 2'b01) begin
      victim_s = 1'b1;
    end else if (valid_r[lk_set_s] == 2'b10) begin
      victim_s = 1'b0;
    end else begin
      victim_s = ~lru_r[lk_set_s];
    end
  end

  // Next-state decode, request priority and bus outputs.
  always_comb begin
    state_s      = state_r;
    ready_s      = 1'b0;
    hit_s        = 1'b0;
    rdata_s      = {DATA_W{1'b0}};
    mem_rd_req_s = 1'b0;
    mem_wr_req_s = 1'b0;
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_wdata_s  = {DATA_W{1'b0}};
    do_flush_s   = 1'b0;
    do_inv_s     = 1'b0;
    do_wr_s      = 1'b0;
    rd_hit_s     = 1'b0;
    fill_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        hit_s = lk_hit_s;
        if (lk_hit_s) begin
          rdata_s = data_r[hit_way_s][lk_set_s][lk_off_s];
        end else begin
          rdata_s = {DATA_W{1'b0}};
        end
        if (bus.flush) begin
          do_flush_s = 1'b1;
        end else if (bus.invalidate) begin
          do_inv_s = 1'b1;
        end else if (bus.wr_req) begin
          do_wr_s = 1'b1;
          state_s = WRITE;
        end else if (bus.rd_req) begin
          if (lk_hit_s) begin
            rd_hit_s = 1'b1;
            ready_s  = 1'b1;
          end else begin
            fill_start_s = 1'b1;
            state_s      = FILL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        mem_rd_req_s = 1'b1;
        mem_addr_s   = {addr_r[ADDR_W-1:WORD_BITS], {WORD_BITS{1'b0}}};
        if (bus.mem_rvalid && beat_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = FILL;
        end
      end
      WRITE: begin
        mem_wr_req_s = 1'b1;
        mem_addr_s   = addr_r;
        mem_wdata_s  = wdata_r;
        if (bus.mem_ack) begin
          ready_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WRITE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign bus.ready      = ready_s;
  assign bus.hit        = hit_s;
  assign bus.rdata      = rdata_s;
  assign bus.mem_rd_req = mem_rd_req_s;
  assign bus.mem_wr_req = mem_wr_req_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;

  // State, valid/LRU bookkeeping, fill beat counter and request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      beat_r   <= {WORD_BITS{1'b0}};
      victim_r <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= 2'b00;
        lru_r[s]   <= 1'b0;
      end
    end else begin
      state_r <= state_s;
      if (do_flush_s) begin
        for (int s = 0; s < SETS; s++) begin
          valid_r[s] <= 2'b00;
          lru_r[s]   <= 1'b0;
        end
      end else if (do_inv_s && lk_hit_s) begin
        valid_r[lk_set_s][hit_way_s] <= 1'b0;
        lru_r[lk_set_s]              <= ~hit_way_s;
      end else if (do_wr_s) begin
        addr_r  <= bus.address;
        wdata_r <= bus.wdata;
      end else if (rd_hit_s) begin
        lru_r[lk_set_s] <= hit_way_s;
      end else if (fill_start_s) begin
        addr_r   <= bus.address;
        victim_r <= victim_s;
        beat_r   <= {WORD_BITS{1'b0}};
      end else if (fill_beat_s) begin
        if (beat_last_s) begin
          valid_r[lk_set_s][victim_r] <= 1'b1;
          lru_r[lk_set_s]             <= victim_r;
          beat_r                      <= {WORD_BITS{1'b0}};
        end else begin
          beat_r <= beat_r + WORD_BITS'(1);
        end
      end else if (wr_ack_s && lk_hit_s) begin
        lru_r[lk_set_s] <= hit_way_s;
      end
    end
  end

  // Tag and data arrays: fill beats into the victim way, write-through hits.
  always_ff @(posedge clk) begin
    if (fill_beat_s) begin
      data_r[victim_r][lk_set_s][beat_r] <= bus.mem_rdata;
      if (beat_last_s) begin
        tag_r[victim_r][lk_set_s] <= lk_tag_s;
      end
    end else if (wr_ack_s && lk_hit_s) begin
      data_r[hit_way_s][lk_set_s][lk_off_s] <= wdata_r;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] read_count_r, miss_count_r;

  // Free-running wrap-around counters of completed reads and fill starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_count_r <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      if (rd_hit_s) begin
        read_count_r <= read_count_r + 32'd1;
      end
      if (fill_start_s) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign read_count = read_count_r;
  assign miss_count = miss_count_r;
`endif
endmodule

// File: tb/tb_param_cache.sv
// Self-checking bench for param_cache: table of operations with a
// read-data scoreboard backed by a write-through memory model.
`timescale 1ns/1ps
module tb_param_cache;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int WORDS  = 2;
  localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_INV = 2'd2, OP_FL = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    int          dly;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] mem_m [int];
  logic [31:0] exp_q [$];
  vec_t vecs [19];

  always #5 clk = ~clk;

  param_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] read_count, miss_count;
`endif

  param_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_STATS_EN
    ,
    .read_count (read_count),
    .miss_count (miss_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [16:0] a);
    if (mem_m.exists(int'(a))) return mem_m[int'(a)];
    return 32'hAAAA_0000 + 32'(a) - 32'h0000_0040;
  endfunction

  task automatic do_read(input logic [16:0] a, input logic exp_hit);
    logic        done;
    int          beat;
    logic [31:0] expd;
    logic [16:0] line;
    line = {a[16:1], 1'b0};
    exp_q.push_back(model_rd(a));
    @(negedge clk);
    bus.address = a;
    bus.rd_req  = 1'b1;
    done = 1'b0;
    beat = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (cyc == 0) chk("rd_first_hit", 64'(bus.hit), 64'(exp_hit));
      if (bus.ready) begin
        bus.mem_rvalid = 1'b0;
        chk("rd_hit_at_ready", 64'(bus.hit), 64'd1);
        expd = exp_q.pop_front();
        chk("rd_data", 64'(bus.rdata), 64'(expd));
        chk("rd_latency", 64'(cyc), exp_hit ? 64'd0 : 64'(WORDS + 1));
        done = 1'b1;
      end else if (bus.mem_rd_req && beat < WORDS) begin
        if (beat == 0) chk("fill_addr", 64'(bus.mem_addr), 64'(line));
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = model_rd(line + 17'(beat));
        beat++;
      end else begin
        bus.mem_rvalid = 1'b0;
      end
      @(negedge clk);
    end
    if (!done) begin
      chk("rd_timeout", 64'd0, 64'd1);
      exp_q.delete();
    end
    bus.rd_req     = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic do_write(input logic [16:0] a, input logic [31:0] d, input int dly);
    logic done;
    mem_m[int'(a)] = d;
    @(negedge clk);
    bus.address = a;
    bus.wdata   = d;
    bus.wr_req  = 1'b1;
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (cyc == 0) begin
        chk("wr_ready_idle", 64'(bus.ready), 64'd0);
      end else begin
        if (cyc == 1) begin
          chk("wr_mem_req", 64'(bus.mem_wr_req), 64'd1);
          chk("wr_mem_addr", 64'(bus.mem_addr), 64'(a));
          chk("wr_mem_data", 64'(bus.mem_wdata), 64'(d));
        end
        if (cyc == dly + 1) begin
          bus.mem_ack = 1'b1;
          #1;
          chk("wr_ready_ack", 64'(bus.ready), 64'd1);
          done = 1'b1;
        end else begin
          chk("wr_ready_wait", 64'(bus.ready), 64'd0);
        end
      end
      @(negedge clk);
    end
    if (!done) chk("wr_timeout", 64'd0, 64'd1);
    bus.wr_req  = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  task automatic do_inv(input logic [16:0] a, input logic is_flush);
    @(negedge clk);
    bus.address = a;
    if (is_flush) bus.flush = 1'b1;
    else bus.invalidate = 1'b1;
    #1;
    chk(is_flush ? "flush_ready" : "inv_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    bus.flush      = 1'b0;
    bus.invalidate = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{op: OP_RD,  addr: 17'h00041, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[1]  = '{op: OP_RD,  addr: 17'h00041, wdata: 32'h0,         exp_hit: 1'b1, dly: 0};
    vecs[2]  = '{op: OP_RD,  addr: 17'h00140, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[3]  = '{op: OP_RD,  addr: 17'h00040, wdata: 32'h0,         exp_hit: 1'b1, dly: 0};
    vecs[4]  = '{op: OP_RD,  addr: 17'h00240, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[5]  = '{op: OP_RD,  addr: 17'h00040, wdata: 32'h0,         exp_hit: 1'b1, dly: 0};
    vecs[6]  = '{op: OP_RD,  addr: 17'h00140, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[7]  = '{op: OP_WR,  addr: 17'h00041, wdata: 32'h1234_5678, exp_hit: 1'b1, dly: 3};
    vecs[8]  = '{op: OP_RD,  addr: 17'h00041, wdata: 32'h0,         exp_hit: 1'b1, dly: 0};
    vecs[9]  = '{op: OP_WR,  addr: 17'h00A00, wdata: 32'h55AA_55AA, exp_hit: 1'b0, dly: 1};
    vecs[10] = '{op: OP_RD,  addr: 17'h00A00, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[11] = '{op: OP_INV, addr: 17'h00040, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[12] = '{op: OP_RD,  addr: 17'h00040, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[13] = '{op: OP_RD,  addr: 17'h00140, wdata: 32'h0,         exp_hit: 1'b1, dly: 0};
    vecs[14] = '{op: OP_FL,  addr: 17'h00000, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[15] = '{op: OP_RD,  addr: 17'h00140, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[16] = '{op: OP_RD,  addr: 17'h00A01, wdata: 32'h0,         exp_hit: 1'b0, dly: 0};
    vecs[17] = '{op: OP_WR,  addr: 17'h00141, wdata: 32'hDEAD_BEEF, exp_hit: 1'b1, dly: 0};
    vecs[18] = '{op: OP_RD,  addr: 17'h00141, wdata: 32'h0,         exp_hit: 1'b1, dly: 0};

    rst            = 1'b1;
    bus.address    = 17'h0;
    bus.wdata      = 32'h0;
    bus.rd_req     = 1'b0;
    bus.wr_req     = 1'b0;
    bus.invalidate = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.mem_rvalid = 1'b0;
    bus.mem_ack    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_hit", 64'(bus.hit), 64'd0);
    chk("rst_mem_rd_req", 64'(bus.mem_rd_req), 64'd0);
    chk("rst_mem_wr_req", 64'(bus.mem_wr_req), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      case (vecs[i].op)
        OP_RD:   do_read(vecs[i].addr, vecs[i].exp_hit);
        OP_WR:   do_write(vecs[i].addr, vecs[i].wdata, vecs[i].dly);
        OP_INV:  do_inv(vecs[i].addr, 1'b0);
        default: do_inv(vecs[i].addr, 1'b1);
      endcase
`ifdef CACHE_STATS_EN
      if (i == 1) begin
        chk("read_count", 64'(read_count), 64'd2);
        chk("miss_count", 64'(miss_count), 64'd1);
      end
`endif
    end

    // Stray memory strobes in IDLE must not disturb the cache.
    @(negedge clk);
    bus.address    = 17'h00141;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    bus.mem_ack    = 1'b1;
    #1;
    chk("stray_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_ack    = 1'b0;
    do_read(17'h00141, 1'b1);

    // Flush wins over a same-cycle read.
    @(negedge clk);
    bus.address = 17'h00141;
    bus.flush   = 1'b1;
    bus.rd_req  = 1'b1;
    #1;
    chk("flush_rd_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    bus.flush  = 1'b0;
    bus.rd_req = 1'b0;
    do_read(17'h00141, 1'b0);

    // Reset after the first fill beat abandons the fill.
    @(negedge clk);
    bus.address = 17'h00041;
    bus.rd_req  = 1'b1;
    @(negedge clk);
    #1;
    chk("midfill_req", 64'(bus.mem_rd_req), 64'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0BAD_0000;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midfill_rst_req", 64'(bus.mem_rd_req), 64'd0);
    chk("midfill_rst_ready", 64'(bus.ready), 64'd0);
    chk("midfill_rst_addr", 64'(bus.mem_addr), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    bus.rd_req = 1'b0;
    do_read(17'h00041, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
